fifo_rr_arbiter: RTL and testbench

Round-robin write arbiter that shares one fifo write port between N_REQ producers.
- Each producer has a valid/ready handshake; the arbiter muxes the granted producer onto fifo wr_en/wr_data and honours fifo wr_ready (not full).
- Burst locking holds a grant for up to MAX_BURST words so producer packets stay contiguous in the queue.
- Sits directly in front of the fifo write side; the fifo read side is untouched.

---
 rtl/fifo_arb_pkg.sv | 26 ++
 rtl/rr_pick.sv | 38 +++
 rtl/fifo_rr_arbiter.sv | 140 ++++++++++++++
 tb/tb_fifo_rr_arbiter.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the fifo write-side round-robin arbiter
// and its pointer-based picker.
//   arb_state_t : arbiter FSM encoding (ARB, LOCK)
//   id_width    : requester index width for n producers
//   cnt_width   : burst counter width able to hold max_burst
//   rr_next     : (ptr + 1) mod n with an explicit wrap, safe for non-power-of-2 n
package fifo_arb_pkg;

   typedef enum logic {
      ARB  = 1'b0,
      LOCK = 1'b1
   } arb_state_t;

   function automatic int id_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic int cnt_width(input int max_burst);
      return $clog2(max_burst + 1);
   endfunction

   function automatic int unsigned rr_next(input int unsigned ptr, input int unsigned n);
      return (ptr + 1 >= n) ? 0 : ptr + 1;
   endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: returns the first set bit of req_val
// searching rr_ptr, rr_ptr+1, ... with wrap at N_REQ-1.
// Ports:
//   req_val [N_REQ]    request vector
//   rr_ptr  [ID_WIDTH] search start index (must be < N_REQ)
//   found              at least one request is set
//   idx     [ID_WIDTH] chosen index, 0 when found = 0
module rr_pick
   import fifo_arb_pkg::*;
#(
   parameter int N_REQ    = 4,
   parameter int ID_WIDTH = $clog2(N_REQ)
) (
   input  logic [N_REQ-1:0]    req_val,
   input  logic [ID_WIDTH-1:0] rr_ptr,
   output logic                found,
   output logic [ID_WIDTH-1:0] idx
);

   int unsigned         p;
   logic [ID_WIDTH-1:0] cand;

   always_comb begin
      found = 1'b0;
      idx   = '0;
      p     = 32'(rr_ptr);
      cand  = '0;
      for (int k = 0; k < N_REQ; k++) begin
         cand = ID_WIDTH'(p);
         if (!found && req_val[cand]) begin
            found = 1'b1;
            idx   = cand;
         end
         p = rr_next(p, N_REQ);
      end
   end

endmodule

// File: rtl/fifo_rr_arbiter.sv
// Round-robin write arbiter sharing one fifo write port among N_REQ
// producers, with burst locking so a producer's packet stays contiguous.
// Build option: define FIFO_ARB_TAG_EN to widen fifo_wr_data to
// {grant_id, data}; arbitration is identical either way.
// Ports:
//   clk, reset (async, active-low)
//   req_val/req_data/req_ready : per-producer valid/ready handshake
//   fifo_wr_en/fifo_wr_data/fifo_wr_ready : fifo write side
//   grant_id/grant_val : current grant (grant_id = 0 when no grant)
//
// state | meaning
// ------+---------------------------------------------------------------
// ARB   | no lock; grant the first valid requester from rr_ptr onward
// LOCK  | lock_id owns the port until MAX_BURST words or it drops req_val
module fifo_rr_arbiter
   import fifo_arb_pkg::*;
#(
   parameter int N_REQ      = 4,
   parameter int DATA_WIDTH = 8,
   parameter int MAX_BURST  = 4,
   parameter int ID_WIDTH   = $clog2(N_REQ)
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [N_REQ-1:0]              req_val,
   input  logic [N_REQ*DATA_WIDTH-1:0]   req_data,
   output logic [N_REQ-1:0]              req_ready,
   output logic                          fifo_wr_en,
`ifdef FIFO_ARB_TAG_EN
   output logic [DATA_WIDTH+ID_WIDTH-1:0] fifo_wr_data,
`else
   output logic [DATA_WIDTH-1:0]          fifo_wr_data,
`endif
   input  logic                          fifo_wr_ready,
   output logic [ID_WIDTH-1:0]           grant_id,
   output logic                          grant_val
);

   localparam int                   CNT_WIDTH = cnt_width(MAX_BURST);
   localparam logic [CNT_WIDTH-1:0] LAST_CNT  = CNT_WIDTH'(MAX_BURST - 1);

   arb_state_t            state, state_n;
   logic [ID_WIDTH-1:0]   rr_ptr, rr_ptr_n;
   logic [ID_WIDTH-1:0]   lock_id, lock_id_n;
   logic [CNT_WIDTH-1:0]  burst_cnt, burst_cnt_n;
   logic                  pick_found;
   logic [ID_WIDTH-1:0]   pick_idx;
   logic                  xfer;
   logic [DATA_WIDTH-1:0] sel_data;

   function automatic logic [ID_WIDTH-1:0] ptr_after(input logic [ID_WIDTH-1:0] id);
      return ID_WIDTH'(rr_next(32'(id), N_REQ));
   endfunction

   rr_pick #(
      .N_REQ    (N_REQ),
      .ID_WIDTH (ID_WIDTH)
   ) u_pick (
      .req_val (req_val),
      .rr_ptr  (rr_ptr),
      .found   (pick_found),
      .idx     (pick_idx)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= ARB;
         rr_ptr    <= '0;
         lock_id   <= '0;
         burst_cnt <= '0;
      end else begin
         state     <= state_n;
         rr_ptr    <= rr_ptr_n;
         lock_id   <= lock_id_n;
         burst_cnt <= burst_cnt_n;
      end
   end

   // Outputs are gated by reset so they drop the instant reset asserts,
   // not one edge later.
   always_comb begin
      grant_val = 1'b0;
      grant_id  = '0;
      if (reset) begin
         if (state == LOCK) begin
            grant_val = 1'b1;
            grant_id  = lock_id;
         end else if (pick_found) begin
            grant_val = 1'b1;
            grant_id  = pick_idx;
         end
      end
      xfer       = grant_val & req_val[grant_id] & fifo_wr_ready;
      fifo_wr_en = xfer;
      req_ready  = '0;
      if (grant_val && fifo_wr_ready) begin
         req_ready[grant_id] = 1'b1;
      end
      sel_data = grant_val ? req_data[int'(grant_id)*DATA_WIDTH +: DATA_WIDTH] : '0;
   end

`ifdef FIFO_ARB_TAG_EN
   assign fifo_wr_data = {grant_id, sel_data};
`else
   assign fifo_wr_data = sel_data;
`endif

   // A lock is only taken on an actual transfer, so a full fifo in ARB
   // leaves the grant free to move to a different requester next cycle.
   always_comb begin
      state_n     = state;
      rr_ptr_n    = rr_ptr;
      lock_id_n   = lock_id;
      burst_cnt_n = burst_cnt;
      case (state)
         ARB: begin
            if (xfer) begin
               if (MAX_BURST > 1) begin
                  state_n     = LOCK;
                  lock_id_n   = grant_id;
                  burst_cnt_n = CNT_WIDTH'(1);
               end else begin
                  rr_ptr_n = ptr_after(grant_id);
               end
            end
         end
         LOCK: begin
            if (!req_val[lock_id] || (xfer && burst_cnt == LAST_CNT)) begin
               state_n     = ARB;
               rr_ptr_n    = ptr_after(lock_id);
               burst_cnt_n = '0;
            end else if (xfer) begin
               burst_cnt_n = burst_cnt + 1'b1;
            end
         end
         default: state_n = ARB;
      endcase
   end

endmodule

// File: tb/tb_fifo_rr_arbiter.sv
// Bench for fifo_rr_arbiter: two instances (4 producers / burst 4, and
// 3 producers / burst 1) compared every cycle against a burst-level model,
// plus literal write-order sequences for the directed scenarios.
module tb_fifo_rr_arbiter;

`ifdef FIFO_ARB_TAG_EN
   localparam int OW = 10;
`else
   localparam int OW = 8;
`endif

   logic        clk = 1'b0;
   logic        reset = 1'b0;

   logic [3:0]  rv0 = '0;
   logic [31:0] rd0 = '0;
   logic        rdy0 = 1'b1;
   logic [3:0]  ready0;
   logic        en0;
   logic [OW-1:0] wd0;
   logic [1:0]  gid0;
   logic        gv0;

   logic [2:0]  rv1 = '0;
   logic [23:0] rd1 = '0;
   logic        rdy1 = 1'b1;
   logic [2:0]  ready1;
   logic        en1;
   logic [OW-1:0] wd1;
   logic [1:0]  gid1;
   logic        gv1;

   int checks = 0;
   int failures = 0;

   // model: per instance, whether a burst owner holds the port, who,
   // how many words it has sent in this burst, and where the search starts
   int  nreq [2] = '{4, 3};
   int  mbur [2] = '{4, 1};
   bit  held [2] = '{0, 0};
   int  owner[2] = '{0, 0};
   int  sent [2] = '{0, 0};
   int  ptr  [2] = '{0, 0};
   int  log0[$];
   int  log1[$];

   always #5 clk = ~clk;

   fifo_rr_arbiter #(.N_REQ(4), .DATA_WIDTH(8), .MAX_BURST(4)) dut (
      .clk(clk), .reset(reset), .req_val(rv0), .req_data(rd0), .req_ready(ready0),
      .fifo_wr_en(en0), .fifo_wr_data(wd0), .fifo_wr_ready(rdy0),
      .grant_id(gid0), .grant_val(gv0)
   );

   fifo_rr_arbiter #(.N_REQ(3), .DATA_WIDTH(8), .MAX_BURST(1)) dut1 (
      .clk(clk), .reset(reset), .req_val(rv1), .req_data(rd1), .req_ready(ready1),
      .fifo_wr_en(en1), .fifo_wr_data(wd1), .fifo_wr_ready(rdy1),
      .grant_id(gid1), .grant_val(gv1)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic model_cmp(input int k, input logic [15:0] rv, input logic [127:0] rd,
                            input logic rdy, input logic [15:0] a_ready, input logic a_en,
                            input logic [OW-1:0] a_data, input logic [1:0] a_gid,
                            input logic a_gval);
      int n;
      int g;
      logic e_en;
      logic [15:0] e_ready;
      logic [OW-1:0] e_data;
      n = nreq[k];
      g = -1;
      if (reset) begin
         if (held[k]) g = owner[k];
         else begin
            for (int j = 0; j < n; j++) begin
               if (g < 0 && rv[4'((ptr[k] + j) % n)]) g = (ptr[k] + j) % n;
            end
         end
      end
      e_en    = (g >= 0) && rv[4'(g)] && rdy;
      e_ready = (g >= 0 && rdy) ? (16'(1) << g) : 16'd0;
      e_data  = '0;
      if (g >= 0) begin
         e_data[7:0] = 8'(rd >> (g * 8));
`ifdef FIFO_ARB_TAG_EN
         e_data[OW-1:8] = 2'(g);
`endif
      end
      chk($sformatf("dut%0d.grant_val", k), 32'(a_gval), 32'(g >= 0));
      chk($sformatf("dut%0d.grant_id", k), 32'(a_gid), (g >= 0) ? 32'(g) : 32'd0);
      chk($sformatf("dut%0d.fifo_wr_en", k), 32'(a_en), 32'(e_en));
      chk($sformatf("dut%0d.req_ready", k), 32'(a_ready), 32'(e_ready));
      chk($sformatf("dut%0d.fifo_wr_data", k), 32'(a_data), 32'(e_data));
      // advance to what the coming clock edge commits
      if (!reset) begin
         held[k] = 0; owner[k] = 0; sent[k] = 0; ptr[k] = 0;
      end else if (held[k]) begin
         if (!rv[4'(owner[k])]) begin
            held[k] = 0;
            ptr[k]  = (owner[k] + 1) % n;
         end else if (e_en) begin
            sent[k]++;
            if (sent[k] == mbur[k]) begin
               held[k] = 0;
               ptr[k]  = (owner[k] + 1) % n;
            end
         end
      end else if (e_en) begin
         if (mbur[k] == 1) ptr[k] = (g + 1) % n;
         else begin
            held[k] = 1; owner[k] = g; sent[k] = 1;
         end
      end
   endtask

   always @(negedge clk) begin
      model_cmp(0, 16'(rv0), 128'(rd0), rdy0, 16'(ready0), en0, wd0, gid0, gv0);
      model_cmp(1, 16'(rv1), 128'(rd1), rdy1, 16'(ready1), en1, wd1, gid1, gv1);
      if (en0) log0.push_back(int'(gid0));
      if (en1) log1.push_back(int'(gid1));
   end

   // seq holds expected producer ids as hex digits, first write leftmost
   task automatic check_seq(input string name, input int k, input int n,
                            input logic [63:0] seq, input bit exact);
      int got;
      int sz;
      sz = (k == 0) ? log0.size() : log1.size();
      if (exact) chk($sformatf("%s.count", name), 32'(sz), 32'(n));
      for (int i = 0; i < n; i++) begin
         if (i < sz) got = (k == 0) ? log0[i] : log1[i];
         else got = -1;
         chk($sformatf("%s[%0d]", name, i), 32'(got), 32'((seq >> ((n - 1 - i) * 4)) & 64'hF));
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
         rd0 = $urandom;
         rd1 = 24'($urandom);
      end
   endtask

   initial begin
      reset = 1'b0; rv0 = 4'hF; rdy0 = 1'b1; rv1 = 3'b111; rdy1 = 1'b1;
      step(2);
      chk("rst.req_ready0", 32'(ready0), 32'd0);
      chk("rst.wr_en0", 32'(en0), 32'd0);
      chk("rst.grant_val0", 32'(gv0), 32'd0);
      chk("rst.req_ready1", 32'(ready1), 32'd0);
      log0.delete(); log1.delete();
      reset = 1'b1;
      step(16);
      check_seq("burst_all", 0, 16, 64'h0000111122223333, 1);
      check_seq("mb1_wrap", 1, 6, 64'h012012, 0);

      log0.delete();
      rv0 = 4'b0110;
      step(12);
      check_seq("pair", 0, 12, 64'h111122221111, 1);

      log0.delete();
      rv0 = 4'b1100;
      step(2);
      rdy0 = 1'b0;
      step(5);
      chk("stall.grant_id", 32'(gid0), 32'd2);
      chk("stall.wr_en", 32'(en0), 32'd0);
      rdy0 = 1'b1;
      step(3);
      check_seq("stall", 0, 5, 64'h22223, 1);

      log0.delete();
      rv0 = 4'b1000;
      step(3);
      rv0 = 4'b1001;
      step(2);
      rv0 = 4'b1000;
      #1;
      chk("early.grant_val", 32'(gv0), 32'd1);
      chk("early.grant_id", 32'(gid0), 32'd0);
      chk("early.wr_en", 32'(en0), 32'd0);
      step(1);
      chk("early.next_grant", 32'(gid0), 32'd3);
      chk("early.next_wr_en", 32'(en0), 32'd1);
      step(1);
      check_seq("early_end", 0, 6, 64'h333003, 1);

      log0.delete();
      rv0 = 4'b0010;
      step(4);
      check_seq("pre_reset", 0, 3, 64'h111, 1);
      reset = 1'b0;
      #1;
      chk("midrst.wr_en", 32'(en0), 32'd0);
      chk("midrst.grant_val", 32'(gv0), 32'd0);
      chk("midrst.req_ready", 32'(ready0), 32'd0);
      chk("midrst.grant_id", 32'(gid0), 32'd0);
      rv0 = 4'hF;
      step(2);
      log0.delete();
      reset = 1'b1;
      step(4);
      check_seq("after_reset", 0, 4, 64'h0000, 1);

      repeat (3000) begin
         rv0  = 4'($urandom);
         rv1  = 3'($urandom);
         rdy0 = ($urandom_range(0, 3) != 0);
         rdy1 = ($urandom_range(0, 3) != 0);
         reset = ($urandom_range(0, 299) != 0);
         step(1);
      end
      reset = 1'b1;
      step(2);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
